// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and models multi-cycle MULT/DIV latency
// with a countdown so the hazard unit can stall HI/LO consumers on busy.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               busy_r;
    logic               nowrite;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               accept;
    logic [63:0]        mul_res;
    logic [63:0]        div_res;

    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        sp = sa * sb;
        return 64'(sp);
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Returns {remainder, quotient}; a zero divisor yields zero (the result is never written).
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return 64'd0;
        return {a % b, a / b};
    endfunction

    // Divide magnitudes, then reapply signs: this sidesteps the 0x80000000 / -1 overflow,
    // whose unsigned magnitude quotient 0x80000000 is already the required answer.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [63:0] ures;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = a[31];
        neg_b = b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        ures  = div_unsigned(mag_a, mag_b);
        q     = (neg_a ^ neg_b) ? (~ures[31:0] + 32'd1) : ures[31:0];
        r     = neg_a ? (~ures[63:32] + 32'd1) : ures[63:32];
        return {r, q};
    endfunction

    assign accept  = op_valid && (state == IDLE) && (op >= OP_MULT) && (op <= OP_MTLO);
    assign mul_res = (op == OP_MULT) ? mul_signed(rs_data, rt_data) : mul_unsigned(rs_data, rt_data);
    assign div_res = (op == OP_DIV)  ? div_signed(rs_data, rt_data) : div_unsigned(rs_data, rt_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            busy_r  <= 1'b0;
            nowrite <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi <= mul_res[63:32];
                                pend_lo <= mul_res[31:0];
                                nowrite <= 1'b0;
                                count   <= CNT_W'(MULT_CYCLES);
                                busy_r  <= 1'b1;
                                state   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi <= div_res[63:32];
                                pend_lo <= div_res[31:0];
                                nowrite <= (rt_data == 32'd0);
                                count   <= CNT_W'(DIV_CYCLES);
                                busy_r  <= 1'b1;
                                state   <= RUN;
                            end
                            OP_MTHI: hi_r <= rs_data;
                            OP_MTLO: lo_r <= rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                        if (!nowrite) begin
                            hi_r <= pend_hi;
                            lo_r <= pend_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign rdata = rd_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, HI/LO results, divide corner cases, MT ops and reset abort.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_sel;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .rd_sel(rd_sel),
        .rdata(rdata), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for exactly one edge, then drop op_valid and scramble operands.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        step();
        op_valid = 1'b0;
        op       = 3'd0;
        rs_data  = 32'hDEAD_BEEF;
        rt_data  = 32'h1234_5678;
    endtask

    // Counts busy cycles starting from the cycle after accept; bounded so it cannot hang.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = 3'd0;
        rs_data = 32'd0; rt_data = 32'd0; rd_sel = 1'b0;
        step(); step();
        reset = 1'b0;

        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdata", rdata, 32'd0);

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_busy_first", {31'd0, busy}, 32'd1);
        check("mult_hi_old", hi, 32'd0);
        wait_idle(n);
        check("mult_busy_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        rd_sel = 1'b1; #1;
        check("mult_rdata_hi", rdata, 32'hFFFF_FFFF);
        rd_sel = 1'b0;

        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(n);
        check("multu_busy_cycles", n, 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        issue(3'd6, 32'h0000_ABCD, 32'd0);
        check("div_busy_mtlo_ignored", lo, 32'hFFFF_FFFE);
        wait_idle(n);
        check("div_busy_cycles", n + 1, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("divovf_busy_cycles", n, 32'd10);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0000_0000);

        issue(3'd5, 32'h0000_0011, 32'd0);
        issue(3'd6, 32'h0000_0022, 32'd0);
        check("mthi_hi", hi, 32'h0000_0011);
        check("mtlo_lo", lo, 32'h0000_0022);
        issue(3'd4, 32'h0000_0007, 32'h0000_0000);
        wait_idle(n);
        check("divz_busy_cycles", n, 32'd10);
        check("divz_hi", hi, 32'h0000_0011);
        check("divz_lo", lo, 32'h0000_0022);

        issue(3'd6, 32'h0000_ABCD, 32'd0);
        check("mtlo_idle_rdata", rdata, 32'h0000_ABCD);
        check("mtlo_no_busy", {31'd0, busy}, 32'd0);

        issue(3'd7, 32'h5555_5555, 32'h0000_0003);
        check("op7_busy", {31'd0, busy}, 32'd0);
        check("op7_hi", hi, 32'h0000_0011);
        check("op7_lo", lo, 32'h0000_ABCD);

        issue(3'd1, 32'h0000_0003, 32'h0000_0004);
        step();
        step();
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        step(); step(); step();
        check("rst_no_late_lo", lo, 32'd0);
        check("rst_no_late_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
